// File: rtl/axi_write_master_pkg.sv
// axi_write_master_pkg: AXI constants, write FSM state encoding and size helper
package axi_write_master_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  typedef logic [2:0] wr_state_t;
  localparam wr_state_t WR_IDLE = 3'd0;
  localparam wr_state_t WR_ADDR = 3'd1;
  localparam wr_state_t WR_DATA = 3'd2;
  localparam wr_state_t WR_RESP = 3'd3;
  localparam wr_state_t WR_DONE = 3'd4;
  function automatic logic [2:0] axi_size(input int width);
    return 3'($clog2(width / 8));
  endfunction
endpackage

// File: rtl/axi_write_master_if.sv
// axi_write_master_if: AXI4 write address, data and response channels
interface axi_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic [LEN_WIDTH-1:0]  AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  WREADY;
  logic                  WVALID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  modport master (
    input  AWREADY, WREADY, BRESP, BVALID,
    output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, WVALID, WDATA, WLAST, BREADY
  );
  modport slave (
    output AWREADY, WREADY, BRESP, BVALID,
    input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, WVALID, WDATA, WLAST, BREADY
  );
endinterface

// File: rtl/axi_write_master.sv
// axi_write_master: one INCR write burst from a FWFT FIFO; AXI_WR_PARALLEL_AW_EN lets W run alongside AW
module axi_write_master
  import axi_write_master_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_write,
  input  logic [ADDR_WIDTH-1:0]          target_write_addr,
  input  logic [WRITE_BURST_LEN-1:0]     target_write_burst_len,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] target_write_data,
  input  logic                           target_write_fifo_empty,
  output logic                           target_write_fifo_pull,
  output logic                           done_write,
  output logic                           error_write,
  axi_write_master_if.master             axi
);
  wr_state_t                  state;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [WRITE_BURST_LEN-1:0] len_q;
  logic [WRITE_BURST_LEN-1:0] beat_cnt;
  logic                       aw_hs;
  logic                       w_en;
  logic                       w_hs;
  logic                       w_last;
`ifdef AXI_WR_PARALLEL_AW_EN
  logic                       aw_done;
  logic                       w_done;
  assign w_en = !rst && !w_done && (state == WR_ADDR || state == WR_DATA) && !target_write_fifo_empty;
`else
  assign w_en = !rst && state == WR_DATA && !target_write_fifo_empty;
`endif
  assign aw_hs                  = axi.AWVALID && axi.AWREADY;
  assign w_hs                   = w_en && axi.WREADY;
  assign w_last                 = beat_cnt == len_q;
  assign axi.AWADDR             = addr_q;
  assign axi.AWLEN              = len_q;
  assign axi.AWSIZE             = state == WR_ADDR ? axi_size(WRITE_CHANNEL_WIDTH) : 3'd0;
  assign axi.AWBURST            = state == WR_ADDR ? AXI_BURST_INCR : 2'b00;
  assign axi.WVALID             = w_en;
  assign axi.WDATA              = w_en ? target_write_data : '0;
  assign axi.WLAST              = w_en && w_last;
  assign target_write_fifo_pull = w_hs;
  assign done_write             = state == WR_DONE;
  // burst sequencing: latch request, address phase, beats, response, level done
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WR_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      error_write <= 1'b0;
      axi.AWVALID <= 1'b0;
      axi.BREADY  <= 1'b0;
`ifdef AXI_WR_PARALLEL_AW_EN
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
`endif
    end else begin
      case (state)
        WR_IDLE: if (start_write) begin
          addr_q      <= target_write_addr;
          len_q       <= target_write_burst_len;
          beat_cnt    <= '0;
          error_write <= 1'b0;
          axi.AWVALID <= 1'b1;
          state       <= WR_ADDR;
`ifdef AXI_WR_PARALLEL_AW_EN
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
`endif
        end
        WR_ADDR, WR_DATA: begin
          if (aw_hs) axi.AWVALID <= 1'b0;
          if (w_hs) beat_cnt <= w_last ? '0 : beat_cnt + 1'b1;
`ifdef AXI_WR_PARALLEL_AW_EN
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs && w_last) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || (w_hs && w_last))) begin
            axi.BREADY <= 1'b1;
            state      <= WR_RESP;
          end else if (aw_hs) state <= WR_DATA;
`else
          if (state == WR_ADDR && aw_hs) state <= WR_DATA;
          if (w_hs && w_last) begin
            axi.BREADY <= 1'b1;
            state      <= WR_RESP;
          end
`endif
        end
        WR_RESP: if (axi.BVALID) begin
          error_write <= axi.BRESP != AXI_RESP_OKAY;
          axi.BREADY  <= 1'b0;
          state       <= WR_DONE;
        end
        WR_DONE: if (!start_write) state <= WR_IDLE;
        default: state <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_write_master.sv
// tb_axi_write_master: directed tests for the AXI write burst master
module tb_axi_write_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_write = 1'b0;
  logic [AW-1:0] target_write_addr = '0;
  logic [LW-1:0] target_write_burst_len = '0;
  logic [DW-1:0] target_write_data = '0;
  logic          target_write_fifo_empty = 1'b1;
  logic          target_write_fifo_pull;
  logic          done_write;
  logic          error_write;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  int            pulls;
  logic          force_empty = 1'b0;
  int            beats, wlast_cnt, wlast_idx, data_bad, aw_hs_cnt, stab_viol, gap_wvalid;
  int            aw_cyc, first_cyc, last_cyc, bready_cyc;
  logic [AW-1:0] aw_addr;
  logic [LW-1:0] aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic          done_seen, err_c1, err_done;

  axi_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) axi ();

  axi_write_master #(.ADDR_WIDTH(AW), .WRITE_CHANNEL_WIDTH(DW), .WRITE_BURST_LEN(LW)) dut (
    .clk(clk), .rst(rst), .start_write(start_write),
    .target_write_addr(target_write_addr), .target_write_burst_len(target_write_burst_len),
    .target_write_data(target_write_data), .target_write_fifo_empty(target_write_fifo_empty),
    .target_write_fifo_pull(target_write_fifo_pull), .done_write(done_write),
    .error_write(error_write), .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic upd();
    target_write_fifo_empty = force_empty || q.size() == 0;
    target_write_data = q.size() > 0 ? q[0] : '0;
  endtask

  task automatic cyc();
    logic p;
    p = target_write_fifo_pull;
    @(posedge clk);
    #1;
    if (p && q.size() > 0) begin
      void'(q.pop_front());
      pulls++;
    end
    upd();
  endtask

  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int aw_delay,
                           input int wstall_at, input int wstall_n, input int gap_at,
                           input int gap_n, input logic [1:0] bresp, input int stop_beats);
    int awv_n, wsl, gl;
    logic pa, pw;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdata;
    awv_n = 0; wsl = wstall_n; gl = gap_n; pa = 0; pw = 0; paddr = '0; pdata = '0;
    q.delete();
    for (int i = 0; i <= len; i++) q.push_back({addr[15:0], 16'(i)});
    pulls = 0; beats = 0; wlast_cnt = 0; wlast_idx = -1; data_bad = 0; aw_hs_cnt = 0;
    stab_viol = 0; gap_wvalid = 0; aw_cyc = -1; first_cyc = -1; last_cyc = -1; bready_cyc = -1;
    done_seen = 0; err_c1 = 1'bx; err_done = 1'bx;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    start_write = 1'b1;
    target_write_addr = addr;
    target_write_burst_len = LW'(len);
    for (int c = 0; c < 2000; c++) begin
      if (stop_beats != 0 && beats == stop_beats) return;
      if (c == 1) begin
        target_write_addr = ~addr;
        target_write_burst_len = ~LW'(len);
      end
      axi.AWREADY = awv_n >= aw_delay;
      axi.WREADY = !(beats == wstall_at && wsl > 0);
      force_empty = pulls == gap_at && gl > 0;
      upd();
      axi.BVALID = axi.BREADY;
      axi.BRESP = axi.BREADY ? bresp : 2'b00;
      #1;
      if (pa && !(axi.AWVALID && axi.AWADDR == paddr)) stab_viol++;
      if (pw && !(axi.WVALID && axi.WDATA == pdata)) stab_viol++;
      pa = axi.AWVALID && !axi.AWREADY; paddr = axi.AWADDR;
      pw = axi.WVALID && !axi.WREADY; pdata = axi.WDATA;
      if (axi.AWVALID) begin
        if (awv_n == 0) aw_cyc = c;
        awv_n++;
      end
      if (axi.AWVALID && axi.AWREADY) begin
        aw_hs_cnt++; aw_addr = axi.AWADDR; aw_len = axi.AWLEN; aw_size = axi.AWSIZE; aw_burst = axi.AWBURST;
      end
      if (axi.WVALID && !axi.WREADY) wsl--;
      if (force_empty) begin
        gl--;
        if (axi.WVALID) gap_wvalid++;
      end
      if (axi.WVALID && axi.WREADY) begin
        if (beats == 0) first_cyc = c;
        last_cyc = c;
        if (axi.WDATA !== {addr[15:0], 16'(beats)}) data_bad++;
        if (axi.WLAST) begin
          wlast_cnt++;
          wlast_idx = beats;
        end
        beats++;
      end
      if (axi.BREADY && bready_cyc < 0) bready_cyc = c;
      if (c == 1) err_c1 = error_write;
      if (done_write) begin
        done_seen = 1;
        err_done = error_write;
        return;
      end
      cyc();
    end
  endtask

  task automatic go_idle();
    start_write = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY} !== 4'b0) begin errors++; $display("FAIL reset_valids got %b exp 0000", {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY}); end
    checks++; if ({done_write, error_write, target_write_fifo_pull} !== 3'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {done_write, error_write, target_write_fifo_pull}); end
    checks++; if ({axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST} !== '0) begin errors++; $display("FAIL reset_aw got %h exp 0", {axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST}); end
  endtask

  task automatic test_basic();
    run_burst(32'd123, 3, 0, -1, 0, -1, 0, 2'b00, 0);
    checks++; if (aw_addr !== 32'd123) begin errors++; $display("FAIL basic_awaddr got %0d exp 123", aw_addr); end
    checks++; if (aw_len !== 8'd3) begin errors++; $display("FAIL basic_awlen got %0d exp 3", aw_len); end
    checks++; if (aw_size !== 3'd2) begin errors++; $display("FAIL basic_awsize got %0d exp 2", aw_size); end
    checks++; if (aw_burst !== 2'd1) begin errors++; $display("FAIL basic_awburst got %0d exp 1", aw_burst); end
    checks++; if (aw_hs_cnt !== 1) begin errors++; $display("FAIL basic_aw_count got %0d exp 1", aw_hs_cnt); end
    checks++; if (beats !== 4 || pulls !== 4) begin errors++; $display("FAIL basic_beats got %0d/%0d exp 4/4", beats, pulls); end
    checks++; if (wlast_cnt !== 1 || wlast_idx !== 3) begin errors++; $display("FAIL basic_wlast got cnt %0d idx %0d exp 1 3", wlast_cnt, wlast_idx); end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL basic_data got %0d bad exp 0", data_bad); end
    checks++; if (aw_cyc !== 1 || first_cyc !== 2 || last_cyc !== 5 || bready_cyc !== 6) begin errors++; $display("FAIL basic_latency got %0d %0d %0d %0d exp 1 2 5 6", aw_cyc, first_cyc, last_cyc, bready_cyc); end
    checks++; if (done_seen !== 1'b1 || err_done !== 1'b0) begin errors++; $display("FAIL basic_done got done %b err %b exp 1 0", done_seen, err_done); end
    cyc();
    #1;
    checks++; if (done_write !== 1'b1 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL basic_done_hold got done %b awvalid %b exp 1 0", done_write, axi.AWVALID); end
    start_write = 1'b0;
    cyc();
    checks++; if (done_write !== 1'b0) begin errors++; $display("FAIL basic_done_drop got %b exp 0", done_write); end
    cyc();
    checks++; if (axi.AWVALID !== 1'b0) begin errors++; $display("FAIL basic_no_retrigger got %b exp 0", axi.AWVALID); end
  endtask

  task automatic test_single();
    run_burst(32'h40, 0, 0, -1, 0, -1, 0, 2'b00, 0);
    checks++; if (beats !== 1 || pulls !== 1) begin errors++; $display("FAIL single_beats got %0d/%0d exp 1/1", beats, pulls); end
    checks++; if (wlast_cnt !== 1 || wlast_idx !== 0) begin errors++; $display("FAIL single_wlast got cnt %0d idx %0d exp 1 0", wlast_cnt, wlast_idx); end
    checks++; if (aw_len !== 8'd0 || first_cyc !== 2 || bready_cyc !== 3) begin errors++; $display("FAIL single_timing got len %0d first %0d bready %0d exp 0 2 3", aw_len, first_cyc, bready_cyc); end
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done_seen); end
    go_idle();
  endtask

  task automatic test_fifo_gap();
    run_burst(32'h200, 7, 0, -1, 0, 2, 3, 2'b00, 0);
    checks++; if (beats !== 8 || pulls !== 8) begin errors++; $display("FAIL gap_beats got %0d/%0d exp 8/8", beats, pulls); end
    checks++; if (gap_wvalid !== 0) begin errors++; $display("FAIL gap_wvalid got %0d exp 0", gap_wvalid); end
    checks++; if (data_bad !== 0 || wlast_idx !== 7) begin errors++; $display("FAIL gap_data got bad %0d lastidx %0d exp 0 7", data_bad, wlast_idx); end
    checks++; if (last_cyc !== 12) begin errors++; $display("FAIL gap_last_cycle got %0d exp 12", last_cyc); end
    go_idle();
  endtask

  task automatic test_stalls();
    run_burst(32'h456, 3, 5, 1, 2, -1, 0, 2'b00, 0);
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL stall_stability got %0d exp 0", stab_viol); end
    checks++; if (aw_addr !== 32'h456 || aw_hs_cnt !== 1) begin errors++; $display("FAIL stall_aw got %h x%0d exp 456 x1", aw_addr, aw_hs_cnt); end
    checks++; if (beats !== 4 || data_bad !== 0) begin errors++; $display("FAIL stall_beats got %0d bad %0d exp 4 0", beats, data_bad); end
    checks++; if (first_cyc !== 7 || last_cyc !== 12) begin errors++; $display("FAIL stall_timing got %0d %0d exp 7 12", first_cyc, last_cyc); end
    go_idle();
  endtask

  task automatic test_slverr();
    run_burst(32'h300, 1, 0, -1, 0, -1, 0, 2'b10, 0);
    checks++; if (done_seen !== 1'b1 || err_done !== 1'b1) begin errors++; $display("FAIL slverr_flag got done %b err %b exp 1 1", done_seen, err_done); end
    go_idle();
    checks++; if (error_write !== 1'b1) begin errors++; $display("FAIL slverr_hold got %b exp 1", error_write); end
    run_burst(32'h310, 1, 0, -1, 0, -1, 0, 2'b00, 0);
    checks++; if (err_c1 !== 1'b0 || err_done !== 1'b0) begin errors++; $display("FAIL slverr_clear got c1 %b done %b exp 0 0", err_c1, err_done); end
    go_idle();
  endtask

  task automatic test_max_len();
    run_burst(32'h1000, 255, 0, -1, 0, -1, 0, 2'b00, 0);
    checks++; if (beats !== 256 || pulls !== 256) begin errors++; $display("FAIL maxlen_beats got %0d/%0d exp 256/256", beats, pulls); end
    checks++; if (wlast_cnt !== 1 || wlast_idx !== 255) begin errors++; $display("FAIL maxlen_wlast got cnt %0d idx %0d exp 1 255", wlast_cnt, wlast_idx); end
    checks++; if (data_bad !== 0 || last_cyc !== 257) begin errors++; $display("FAIL maxlen_data got bad %0d last %0d exp 0 257", data_bad, last_cyc); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    run_burst(32'h55, 7, 0, -1, 0, -1, 0, 2'b00, 3);
    start_write = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (target_write_fifo_pull !== 1'b0) begin errors++; $display("FAIL rstmid_pull got %b exp 0", target_write_fifo_pull); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if ({axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, done_write, error_write, target_write_fifo_pull} !== 7'b0) begin errors++; $display("FAIL rstmid_ctrl got %b exp 0", {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, done_write, error_write, target_write_fifo_pull}); end
    checks++; if ({axi.WDATA, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST} !== '0) begin errors++; $display("FAIL rstmid_bus got %h exp 0", {axi.WDATA, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST}); end
    checks++; if (pulls !== 3) begin errors++; $display("FAIL rstmid_pulls got %0d exp 3", pulls); end
    run_burst(32'd789, 1, 0, -1, 0, -1, 0, 2'b00, 0);
    checks++; if (aw_addr !== 32'd789 || aw_len !== 8'd1) begin errors++; $display("FAIL rstmid_next_aw got %0d len %0d exp 789 1", aw_addr, aw_len); end
    checks++; if (beats !== 2 || pulls !== 2 || wlast_idx !== 1 || data_bad !== 0) begin errors++; $display("FAIL rstmid_next_beats got %0d/%0d idx %0d bad %0d exp 2/2 1 0", beats, pulls, wlast_idx, data_bad); end
    checks++; if (done_seen !== 1'b1 || err_done !== 1'b0) begin errors++; $display("FAIL rstmid_next_done got %b %b exp 1 0", done_seen, err_done); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_fifo_gap();
    test_stalls();
    test_slverr();
    test_max_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
